// File: rtl/alu_multicycle.sv
// alu_multicycle: WIDTH-bit signed ALU for the accumulator datapath.
// Single-cycle ADD/SUB/logic/shift ops. Iterative sign-magnitude MPY. Optional
// restoring DIV, enabled by defining ALU_DIV_EN.
// Results are held in BR (low/quotient) and MR (high/remainder). C9/C10 gate
// BR/MR onto the bus and clear them at the following edge.
module alu_multicycle #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_acc_alu_p,
    input  logic [WIDTH-1:0] i_acc_alu_q,
    input  logic [3:0]       ctrl_alu_op,
    input  logic             ctrl_alu_en,
    output logic             o_busy,
    output logic             o_done,
    input  logic             C9,
    input  logic             C10,
    output logic [WIDTH-1:0] o_br,
    output logic [WIDTH-1:0] o_mr,
    output logic [4:0]       o_flags,
    input  logic             i_user_sample,
    output logic [WIDTH-1:0] o_mr_user
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] WV   = WIDTH[WIDTH-1:0];

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MPY = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
`ifdef ALU_DIV_EN
    localparam logic [3:0]       OP_DIV = 4'd8;
    localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] br_q, mr_q;
    logic             zf_q, cf_q, of_q, nf_q, done_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] p_q, q_q;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d, mag_q;
    logic             neg_p_q, neg_q_q;
    logic [CW-1:0]    cnt_q;

    logic             is_iter;
    logic [WIDTH-1:0] abs_p, abs_q;
    logic [WIDTH:0]   sum_m;

    logic [WIDTH-1:0]   res_br, res_mr;
    logic               res_mr_we, res_zf, res_cf, res_of, res_nf;
    logic [2*WIDTH-1:0] prod_mag, prod_s;

    // Operand magnitudes and classification of the requested op
    always_comb begin
        abs_p   = i_acc_alu_p[WIDTH-1] ? -i_acc_alu_p : i_acc_alu_p;
        abs_q   = i_acc_alu_q[WIDTH-1] ? -i_acc_alu_q : i_acc_alu_q;
        is_iter = (ctrl_alu_op == OP_MPY);
`ifdef ALU_DIV_EN
        if (ctrl_alu_op == OP_DIV && i_acc_alu_q != '0) begin
            is_iter = 1'b1;
        end
`endif
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: starts are only accepted in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ctrl_alu_en) state_d = is_iter ? S_ITER : S_DONE;
            S_ITER:  if (cnt_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One iteration step: shift-add for MPY, restoring subtract for DIV
    always_comb begin
        sum_m = hi_q + {1'b0, mag_q};
        if (lo_q[0]) begin
            {hi_d, lo_d} = {sum_m, lo_q} >> 1;
        end else begin
            {hi_d, lo_d} = {hi_q, lo_q} >> 1;
        end
`ifdef ALU_DIV_EN
        if (op_q == OP_DIV) begin
            logic [WIDTH:0] rs, diff;
            rs   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
            diff = rs - {1'b0, mag_q};
            if (!diff[WIDTH]) begin
                hi_d = diff;
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = rs;
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Result and flag computation from the latched operands (used in DONE)
    always_comb begin
        res_br    = '0;
        res_mr    = mr_q;
        res_mr_we = 1'b0;
        res_cf    = 1'b0;
        res_of    = 1'b0;
        prod_mag  = {hi_q[WIDTH-1:0], lo_q};
        prod_s    = (neg_p_q ^ neg_q_q) ? -prod_mag : prod_mag;
        case (op_q)
            OP_ADD: begin
                {res_cf, res_br} = {1'b0, p_q} + {1'b0, q_q};
                res_of = (p_q[WIDTH-1] == q_q[WIDTH-1]) && (res_br[WIDTH-1] != p_q[WIDTH-1]);
            end
            OP_SUB: begin
                {res_cf, res_br} = {1'b0, p_q} - {1'b0, q_q};
                res_of = (p_q[WIDTH-1] != q_q[WIDTH-1]) && (res_br[WIDTH-1] != p_q[WIDTH-1]);
            end
            OP_MPY: begin
                {res_mr, res_br} = prod_s;
                res_mr_we = 1'b1;
                res_of    = (res_mr != {WIDTH{res_br[WIDTH-1]}});
            end
            OP_AND: res_br = p_q & q_q;
            OP_OR:  res_br = p_q | q_q;
            OP_NOT: res_br = ~q_q;
            OP_SHR: begin
                if (q_q == '0) begin
                    res_br = p_q;
                end else if (q_q >= WV) begin
                    res_br = {WIDTH{p_q[WIDTH-1]}};
                    res_cf = p_q[WIDTH-1];
                end else begin
                    res_br = $signed(p_q) >>> q_q;
                    res_cf = |(p_q & (ONE << (q_q - ONE)));
                end
            end
            OP_SHL: begin
                if (q_q == '0) begin
                    res_br = p_q;
                end else if (q_q >= WV) begin
                    res_br = '0;
                end else begin
                    res_br = p_q << q_q;
                    res_cf = |(p_q & (ONE << (WV - q_q)));
                end
            end
`ifdef ALU_DIV_EN
            OP_DIV: begin
                res_mr_we = 1'b1;
                if (q_q == '0) begin
                    res_br = '1;
                    res_mr = p_q;
                    res_of = 1'b1;
                end else begin
                    res_br = (neg_p_q ^ neg_q_q) ? -lo_q : lo_q;
                    res_mr = neg_p_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
                    res_of = (p_q == MINNEG) && (q_q == '1);
                end
            end
`endif
            default: res_br = '0;
        endcase
        res_zf = res_mr_we ? ({res_mr, res_br} == '0) : (res_br == '0);
        res_nf = (op_q == OP_MPY) ? res_mr[WIDTH-1] : res_br[WIDTH-1];
    end

    // Datapath: operand latch, iteration, writeback, and bus-side clears.
    // A completing op takes priority over C9/C10 clears at the same edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            br_q    <= '0;
            mr_q    <= '0;
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
            of_q    <= 1'b0;
            nf_q    <= 1'b0;
            done_q  <= 1'b0;
            op_q    <= '0;
            p_q     <= '0;
            q_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mag_q   <= '0;
            neg_p_q <= 1'b0;
            neg_q_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ctrl_alu_en) begin
                        op_q    <= ctrl_alu_op;
                        p_q     <= i_acc_alu_p;
                        q_q     <= i_acc_alu_q;
                        neg_p_q <= i_acc_alu_p[WIDTH-1];
                        neg_q_q <= i_acc_alu_q[WIDTH-1];
                        cnt_q   <= '0;
                        hi_q    <= '0;
                        if (ctrl_alu_op == OP_MPY) begin
                            lo_q  <= abs_q;
                            mag_q <= abs_p;
                        end else begin
                            lo_q  <= abs_p;
                            mag_q <= abs_q;
                        end
                    end
                end
                S_ITER: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
            if (state_q == S_DONE) begin
                br_q   <= res_br;
                if (res_mr_we) mr_q <= res_mr;
                zf_q   <= res_zf;
                cf_q   <= res_cf;
                of_q   <= res_of;
                nf_q   <= res_nf;
                done_q <= 1'b1;
            end else begin
                if (C9)  br_q <= '0;
                if (C10) mr_q <= '0;
            end
        end
    end

    assign o_busy    = (state_q == S_ITER);
    assign o_done    = done_q;
    assign o_br      = C9 ? br_q : '0;
    assign o_mr      = C10 ? mr_q : '0;
    assign o_mr_user = i_user_sample ? mr_q : '0;
    assign o_flags   = {zf_q, cf_q, of_q, nf_q, |mr_q};

endmodule
